// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised accumulator-style CPU with loadable program
// memory, two-cycle fetch/execute, register ALU, Z/C flags and branches.
module cpu_core_p #(
  parameter int DATA_W  = 8,
  parameter int RSEL_W  = 2,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 4 + 2*RSEL_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               illegal
);

  localparam int NREG  = 2**RSEL_W;
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_EXEC, S_HALT
  } state_t;

  logic [INSTR_W-1:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  regs_q [NREG];
  logic [DATA_W-1:0]  regs_d [NREG];
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               ov_q, ov_d;
  logic [DATA_W-1:0]  od_q, od_d;
  logic               ill_q, ill_d;

  logic [3:0]         op;
  logic [RSEL_W-1:0]  rd, rs;
  logic [DATA_W-1:0]  imm, a, b;
  logic [DATA_W:0]    sum_w, dif_w;
  logic [DATA_W-1:0]  res;
  logic               alu_wr;
  logic               idle;
  logic [ADDR_W-1:0]  pc_inc, jt;

  assign op     = ir_q[INSTR_W-1 -: 4];
  assign rd     = ir_q[INSTR_W-5 -: RSEL_W];
  assign rs     = ir_q[DATA_W +: RSEL_W];
  assign imm    = ir_q[DATA_W-1:0];
  assign a      = regs_q[rd];
  assign b      = regs_q[rs];
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign dif_w  = {1'b0, a} - {1'b0, b};
  assign pc_inc = pc_q + ADDR_W'(1);
  assign jt     = imm[ADDR_W-1:0];
  assign idle   = (state_q == S_IDLE) || (state_q == S_HALT);

  assign dbg_data   = regs_q[dbg_sel];
  assign pc         = pc_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign illegal    = ill_q;

  // Program store: host writes only while the core is stopped.
  always_ff @(posedge clk) begin
    if (reset && prog_we && idle)
      mem[prog_addr] <= prog_data;
  end

  // Next-state: sequencing, fetch latch and instruction execution.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    z_d     = z_q;
    c_d     = c_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    ill_d   = ill_q;
    res     = '0;
    alu_wr  = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = mem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          4'h0: ;
          4'h1: regs_d[rd] = imm;
          4'h2: regs_d[rd] = b;
          4'h3: begin
            res    = sum_w[DATA_W-1:0];
            c_d    = sum_w[DATA_W];
            alu_wr = 1'b1;
          end
          4'h4: begin
            res    = dif_w[DATA_W-1:0];
            c_d    = dif_w[DATA_W];
            alu_wr = 1'b1;
          end
          4'h5: begin
            res    = a & b;
            alu_wr = 1'b1;
          end
          4'h6: begin
            res    = a | b;
            alu_wr = 1'b1;
          end
          4'h7: begin
            res    = a ^ b;
            alu_wr = 1'b1;
          end
          4'h8: begin
            res    = {a[DATA_W-2:0], 1'b0};
            c_d    = a[DATA_W-1];
            alu_wr = 1'b1;
          end
          4'h9: pc_d = jt;
          4'hA: if (z_q) pc_d = jt;
          4'hB: if (c_q) pc_d = jt;
          4'hC: begin
            od_d = a;
            ov_d = 1'b1;
          end
          4'hF: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ill_d = 1'b1;
        endcase
        if (alu_wr) begin
          regs_d[rd] = res;
          z_d        = (res == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed and random programs checked against an
// instruction-level model of the cpu_core_p architecture.
module tb_cpu_core_p;

  localparam int DATA_W = 8;
  localparam int RSEL_W = 2;
  localparam int ADDR_W = 4;
  localparam int IW     = 16;
  localparam int DEPTH  = 16;
  localparam int NREG   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [IW-1:0]     prog_data;
  logic [RSEL_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W-1:0] pc;
  logic              busy, halted;
  logic              zero_flag, carry_flag;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              illegal;

  cpu_core_p #(
    .DATA_W(DATA_W), .RSEL_W(RSEL_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .pc(pc), .busy(busy),
    .halted(halted), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .out_valid(out_valid),
    .out_data(out_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // architectural model state
  logic [IW-1:0] tb_mem [DEPTH];
  int m_regs [NREG];
  int m_z, m_c, m_ill, m_od, m_pc, m_halted, m_hcyc;
  int m_outs [$];
  int d_outs [$];
  int d_hcyc;
  int pulses;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(int op, int rd, int rs, int imm);
    return {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 0;
    m_z = 0; m_c = 0; m_ill = 0; m_od = 0;
    m_pc = 0; m_halted = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic load(input int adr, input logic [15:0] d);
    prog_we = 1'b1;
    prog_addr = adr[3:0];
    prog_data = d;
    tick();
    prog_we = 1'b0;
    tb_mem[adr] = d;
  endtask

  // Execute up to nmax instructions from address 0.
  task automatic run_model(input int nmax);
    int pcv, op, rd, rs, imm, a, b, s, nxt;
    logic [15:0] ins;
    pcv = 0;
    m_outs.delete();
    m_hcyc = -1;
    m_halted = 0;
    for (int i = 0; i < nmax; i++) begin
      ins = tb_mem[pcv];
      op = int'(ins[15:12]);
      rd = int'(ins[11:10]);
      rs = int'(ins[9:8]);
      imm = int'(ins[7:0]);
      a = m_regs[rd];
      b = m_regs[rs];
      nxt = (pcv + 1) % DEPTH;
      case (op)
        1: m_regs[rd] = imm;
        2: m_regs[rd] = b;
        3: begin
          s = a + b;
          m_c = (s > 255) ? 1 : 0;
          m_regs[rd] = s % 256;
        end
        4: begin
          m_c = (b > a) ? 1 : 0;
          m_regs[rd] = (a - b + 256) % 256;
        end
        5: m_regs[rd] = a & b;
        6: m_regs[rd] = a | b;
        7: m_regs[rd] = a ^ b;
        8: begin
          s = a * 2;
          m_c = (s > 255) ? 1 : 0;
          m_regs[rd] = s % 256;
        end
        9: nxt = imm % DEPTH;
        10: if (m_z == 1) nxt = imm % DEPTH;
        11: if (m_c == 1) nxt = imm % DEPTH;
        12: begin
          m_od = a;
          m_outs.push_back(a);
        end
        13, 14: m_ill = 1;
        default: ;
      endcase
      if (op >= 3 && op <= 8)
        m_z = (m_regs[rd] == 0) ? 1 : 0;
      if (op == 15) begin
        m_halted = 1;
        m_hcyc = 2 * (i + 1);
        break;
      end
      pcv = nxt;
    end
    m_pc = pcv;
  endtask

  // Start the core and clock it n cycles; optional write alongside
  // run, and optional write+run injected at cycle ic while busy.
  task automatic run_for(input int n, input bit sw, input int sa,
                         input logic [15:0] sd, input int ic,
                         input int ia, input logic [15:0] id);
    d_outs.delete();
    d_hcyc = -1;
    if (sw) begin
      prog_we = 1'b1;
      prog_addr = sa[3:0];
      prog_data = sd;
      tb_mem[sa] = sd;
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    prog_we = 1'b0;
    for (int c = 1; c <= n; c++) begin
      if (c == ic) begin
        prog_we = 1'b1;
        prog_addr = ia[3:0];
        prog_data = id;
        run = 1'b1;
      end
      tick();
      prog_we = 1'b0;
      run = 1'b0;
      if (out_valid) d_outs.push_back(int'(out_data));
      if (halted && d_hcyc < 0) d_hcyc = c;
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".hcyc"}, d_hcyc, m_hcyc);
    chk({tag, ".nout"}, d_outs.size(), m_outs.size());
    for (int i = 0; i < d_outs.size() && i < m_outs.size(); i++)
      chk($sformatf("%s.out%0d", tag, i), d_outs[i], m_outs[i]);
    chk({tag, ".odata"}, out_data, m_od);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = i[1:0];
      #1;
      chk($sformatf("%s.r%0d", tag, i), dbg_data, m_regs[i]);
    end
    chk({tag, ".z"}, zero_flag, m_z);
    chk({tag, ".c"}, carry_flag, m_c);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".ill"}, illegal, m_ill);
    chk({tag, ".halted"}, halted, m_halted);
    chk({tag, ".busy"}, busy, m_halted == 0);
  endtask

  task automatic load_prog1();
    load(0, enc(1, 0, 0, 5));
    load(1, enc(1, 1, 0, 3));
    load(2, enc(3, 0, 1, 0));
    load(3, enc(12, 0, 0, 0));
    load(4, enc(15, 0, 0, 0));
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    dbg_sel = '0;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();

    // reset state
    chk("rst.busy", busy, 0);
    chk("rst.halted", halted, 0);
    chk("rst.pc", pc, 0);
    chk("rst.z", zero_flag, 0);
    chk("rst.c", carry_flag, 0);
    chk("rst.ov", out_valid, 0);
    chk("rst.od", out_data, 0);
    chk("rst.ill", illegal, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = i[1:0];
      #1;
      chk($sformatf("rst.r%0d", i), dbg_data, 0);
    end
    for (int i = 0; i < DEPTH; i++) load(i, '0);

    // 5 + 3, output and halt
    load_prog1();
    run_for(14, 0, 0, '0, -1, 0, '0);
    run_model(7);
    compare("p1");
    chk("p1.halt10", d_hcyc, 10);
    chk("p1.out8", d_outs.size() > 0 ? d_outs[0] : -1, 8);

    // carry/zero from ADD, then SUB borrow after restart
    load(0, enc(1, 0, 0, 8'hFF));
    load(1, enc(1, 1, 0, 1));
    load(2, enc(3, 0, 1, 0));
    load(3, enc(15, 0, 0, 0));
    run_for(10, 0, 0, '0, -1, 0, '0);
    run_model(5);
    compare("p2a");
    chk("p2a.zc", {zero_flag, carry_flag}, 2'b11);
    load(0, enc(4, 0, 1, 0));
    load(1, enc(15, 0, 0, 0));
    run_for(6, 0, 0, '0, -1, 0, '0);
    run_model(3);
    compare("p2b");
    dbg_sel = 2'd0;
    #1;
    chk("p2b.ff", dbg_data, 8'hFF);

    // countdown loop: 11 instructions to HALT
    load(0, enc(1, 0, 0, 3));
    load(1, enc(1, 1, 0, 1));
    load(2, enc(4, 0, 1, 0));
    load(3, enc(10, 0, 0, 5));
    load(4, enc(9, 0, 0, 2));
    load(5, enc(15, 0, 0, 0));
    run_for(30, 0, 0, '0, -1, 0, '0);
    run_model(15);
    compare("loop");
    chk("loop.cyc22", d_hcyc, 22);

    // pc wrap past an illegal opcode at the last address
    for (int i = 0; i < 15; i++) load(i, enc(0, 0, 0, 0));
    load(15, enc(13, 0, 0, 0));
    run_for(40, 0, 0, '0, -1, 0, '0);
    run_model(20);
    compare("wrap");
    chk("wrap.ill", illegal, 1);
    do_reset();
    chk("wrap.illclr", illegal, 0);

    // reset while ADD is executing
    load_prog1();
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid.busy", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    chk("mid.busy0", busy, 0);
    chk("mid.pc", pc, 0);
    chk("mid.halted", halted, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = i[1:0];
      #1;
      chk($sformatf("mid.r%0d", i), dbg_data, 0);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    chk("mid.noout", pulses, 0);
    run_for(14, 0, 0, '0, -1, 0, '0);
    run_model(7);
    compare("mid.rerun");

    // write and run while busy are both ignored
    run_for(14, 0, 0, '0, 3, 3, enc(15, 0, 0, 0));
    run_model(7);
    compare("busyw");

    // random programs, with a write alongside each run strobe
    for (int t = 0; t < 8; t++) begin
      if (m_halted == 0) do_reset();
      for (int i = 0; i < DEPTH; i++)
        load(i, 16'($urandom));
      run_for(40, 1, int'($urandom_range(15, 0)), 16'($urandom),
              -1, 0, '0);
      run_model(20);
      compare($sformatf("rnd%0d", t));
      m_halted = halted ? 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
